clock_frequency_divider: RTL and testbench

//   Divides a fast board clock down to a slow, 50%-duty clock that paces user-facing logic.
//   The chess layout/cursor logic runs at 10 Hz so held keys move one square per tick.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_counter.sv | 29 ++
 rtl/clock_frequency_divider.sv | 62 ++++++
 tb/tb_clock_frequency_divider.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared divider arithmetic for clock_frequency_divider and any module
// that needs to predict its tick timing.
package clkdiv_pkg;

  function automatic int calc_half_period(input int inHz, input int outHz);
    int half;
    half = (outHz > 0) ? inHz / (2 * outHz) : 1;
    return (half < 1) ? 1 : half;
  endfunction

  function automatic int calc_cnt_w(input int half);
    int w;
    w = $clog2(half);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Modulo-N up-counter with terminal-count flag; wraps explicitly at N-1.
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int MODULUS = 5,
  parameter int CNT_W   = 3
) (
  input  logic InClock,
  input  logic resetApp,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] count;

  assign terminal = (count == LAST);

  always_ff @(posedge InClock or posedge resetApp) begin
    if (resetApp) begin
      count <= '0;
    end else if (terminal) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_frequency_divider.sv
// 50%-duty clock divider. Define CLKDIV_TICK_EN to add a one-cycle
// InClock-domain Tick coincident with each OutClock rise.
module clock_frequency_divider
  import clkdiv_pkg::*;
#(
  parameter int INPUT_FREQUENCY  = 50_000_000,
  parameter int OUTPUT_FREQUENCY = 10
) (
  input  logic InClock,
  input  logic resetApp,
  output logic OutClock
`ifdef CLKDIV_TICK_EN
  ,
  output logic Tick
`endif
);

  localparam int HALF_PERIOD =
    calc_half_period(INPUT_FREQUENCY, OUTPUT_FREQUENCY);
  localparam int CNT_W = calc_cnt_w(HALF_PERIOD);

  if (OUTPUT_FREQUENCY <= 0) begin : gBadOut
    $error("OUTPUT_FREQUENCY must be positive");
  end
  if (INPUT_FREQUENCY <= 0) begin : gBadIn
    $error("INPUT_FREQUENCY must be positive");
  end
  if (2 * OUTPUT_FREQUENCY > INPUT_FREQUENCY) begin : gBadRatio
    $error("OUTPUT_FREQUENCY exceeds INPUT_FREQUENCY/2");
  end

  logic terminal;

  clkdiv_counter #(
    .MODULUS (HALF_PERIOD),
    .CNT_W   (CNT_W)
  ) uCounter (
    .InClock  (InClock),
    .resetApp (resetApp),
    .terminal (terminal)
  );

  always_ff @(posedge InClock or posedge resetApp) begin
    if (resetApp) begin
      OutClock <= 1'b0;
    end else if (terminal) begin
      OutClock <= ~OutClock;
    end
  end

`ifdef CLKDIV_TICK_EN
  // High on the same edge that takes OutClock 0->1
  always_ff @(posedge InClock or posedge resetApp) begin
    if (resetApp) begin
      Tick <= 1'b0;
    end else begin
      Tick <= terminal & ~OutClock;
    end
  end
`endif

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Self-checking bench: three divider instances (HALF=5, HALF=1, floored
// HALF=5) checked against an edge-count model through scoreboard queues.
module tb_clock_frequency_divider;

  logic InClock;
  logic resetApp;
  logic outA, outB, outC;
`ifdef CLKDIV_TICK_EN
  logic tickA, tickB, tickC;
`endif

  int nChecks;
  int nFails;

  logic expA[$];
  logic expB[$];
  logic expC[$];

  clock_frequency_divider #(
    .INPUT_FREQUENCY (100),
    .OUTPUT_FREQUENCY(10)
  ) dutA (
    .InClock (InClock),
    .resetApp(resetApp),
    .OutClock(outA)
`ifdef CLKDIV_TICK_EN
    ,
    .Tick    (tickA)
`endif
  );

  clock_frequency_divider #(
    .INPUT_FREQUENCY (20),
    .OUTPUT_FREQUENCY(10)
  ) dutB (
    .InClock (InClock),
    .resetApp(resetApp),
    .OutClock(outB)
`ifdef CLKDIV_TICK_EN
    ,
    .Tick    (tickB)
`endif
  );

  clock_frequency_divider #(
    .INPUT_FREQUENCY (110),
    .OUTPUT_FREQUENCY(10)
  ) dutC (
    .InClock (InClock),
    .resetApp(resetApp),
    .OutClock(outC)
`ifdef CLKDIV_TICK_EN
    ,
    .Tick    (tickC)
`endif
  );

  initial InClock = 1'b0;
  always #5 InClock = ~InClock;

  task automatic releaseReset();
    @(negedge InClock);
    resetApp = 1'b0;
  endtask

  task automatic test_reset();
    resetApp = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge InClock);
      #1;
      nChecks++;
      if (outA !== 1'b0 || outB !== 1'b0 || outC !== 1'b0) begin
        nFails++;
        $display("FAIL reset edge %0d: A=%b B=%b C=%b required 0",
                 e, outA, outB, outC);
      end
    end
  endtask

  // Model: after edge e from release, out = (e / half) is odd.
  task automatic test_divide();
    int lastRise;
    logic prevA;
    lastRise = 0;
    prevA = 1'b0;
    releaseReset();
    for (int e = 1; e <= 80; e++) begin
      expA.push_back(1'((e / 5) % 2));
      expB.push_back(1'(e % 2));
      expC.push_back(1'((e / 5) % 2));
      @(posedge InClock);
      #1;
      begin
        logic a, b, c;
        a = expA.pop_front();
        b = expB.pop_front();
        c = expC.pop_front();
        nChecks++;
        if (outA !== a) begin
          nFails++;
          $display("FAIL divA edge %0d: got %b required %b", e, outA, a);
        end
        nChecks++;
        if (outB !== b) begin
          nFails++;
          $display("FAIL divB edge %0d: got %b required %b", e, outB, b);
        end
        nChecks++;
        if (outC !== c) begin
          nFails++;
          $display("FAIL divC edge %0d: got %b required %b", e, outC, c);
        end
      end
      if (outA === 1'b1 && prevA === 1'b0) begin
        if (lastRise > 0) begin
          nChecks++;
          if (e - lastRise != 10) begin
            nFails++;
            $display("FAIL period: got %0d required 10", e - lastRise);
          end
        end
        lastRise = e;
      end
      if (outA === 1'b0 && prevA === 1'b1 && lastRise > 0) begin
        nChecks++;
        if (e - lastRise != 5) begin
          nFails++;
          $display("FAIL highTime: got %0d required 5", e - lastRise);
        end
      end
      prevA = outA;
    end
  endtask

  task automatic test_reset_mid();
    time t0;
    resetApp = 1'b1;
    repeat (2) @(posedge InClock);
    releaseReset();
    repeat (7) @(posedge InClock);
    #1;
    nChecks++;
    if (outA !== 1'b1) begin
      nFails++;
      $display("FAIL midHigh: got %b required 1", outA);
    end
    t0 = $time;
    resetApp = 1'b1;
    fork
      wait (outA === 1'b0);
      #1;
    join_any
    disable fork;
    nChecks++;
    if (outA !== 1'b0 || $time != t0) begin
      nFails++;
      $display("FAIL asyncReset: got %b at %0t required 0 at %0t",
               outA, $time, t0);
    end
    repeat (2) @(posedge InClock);
    releaseReset();
    for (int e = 1; e <= 10; e++) begin
      expA.push_back(1'((e / 5) % 2));
      @(posedge InClock);
      #1;
      begin
        logic a;
        a = expA.pop_front();
        nChecks++;
        if (outA !== a) begin
          nFails++;
          $display("FAIL restart edge %0d: got %b required %b", e, outA, a);
        end
      end
    end
  endtask

`ifdef CLKDIV_TICK_EN
  task automatic test_tick();
    int ticks;
    int rises;
    logic prevA;
    ticks = 0;
    rises = 0;
    prevA = 1'b0;
    resetApp = 1'b1;
    @(posedge InClock);
    #1;
    nChecks++;
    if (tickA !== 1'b0 || tickB !== 1'b0 || tickC !== 1'b0) begin
      nFails++;
      $display("FAIL tickReset: A=%b B=%b C=%b required 0",
               tickA, tickB, tickC);
    end
    releaseReset();
    for (int e = 1; e <= 100; e++) begin
      expA.push_back(e % 10 == 5);
      expB.push_back(e % 2 == 1);
      @(posedge InClock);
      #1;
      begin
        logic a, b;
        a = expA.pop_front();
        b = expB.pop_front();
        nChecks++;
        if (tickA !== a) begin
          nFails++;
          $display("FAIL tickA edge %0d: got %b required %b", e, tickA, a);
        end
        nChecks++;
        if (tickB !== b) begin
          nFails++;
          $display("FAIL tickB edge %0d: got %b required %b", e, tickB, b);
        end
      end
      if (tickA === 1'b1) ticks++;
      if (outA === 1'b1 && prevA === 1'b0) rises++;
      prevA = outA;
    end
    nChecks++;
    if (ticks != 10 || rises != 10) begin
      nFails++;
      $display("FAIL tickCount: ticks=%0d rises=%0d required 10",
               ticks, rises);
    end
  endtask
`endif

  initial begin
    nChecks = 0;
    nFails = 0;
    resetApp = 1'b1;
    test_reset();
    test_divide();
    test_reset_mid();
`ifdef CLKDIV_TICK_EN
    test_tick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
